wb_arbiter: RTL and testbench

- Shares the register file's single write port between three result producers: req0 = ALU, req1 = load/store unit, req2 = multi-cycle mul/div unit.
- Each producer uses a valid/ready handshake. Requesters are granted in round-robin order.
- Drives a registered write (wb_we/wb_rd/wb_data) into the regfile write port.
- Holds a per-register in-flight scoreboard, so the issue stage can stall on read-after-write hazards.

---
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter for three result producers, with a per-register
// in-flight scoreboard. Define WB_FWD_EN to forward the committing value to hazard queries.
module wb_arbiter #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 4,
  parameter int unsigned CNTW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        req_valid,
  input  logic [3*AW-1:0]   req_rd,
  input  logic [3*XLEN-1:0] req_data,
  output logic [2:0]        req_ready,
  input  logic              wb_stall,
  output logic              wb_we,
  output logic [AW-1:0]     wb_rd,
  output logic [XLEN-1:0]   wb_data,
  input  logic              alloc_valid,
  input  logic [AW-1:0]     alloc_rd,
  output logic              alloc_ready,
  input  logic [AW-1:0]     rs1,
  input  logic [AW-1:0]     rs2,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic [XLEN-1:0]   rs1_fwd_val,
  output logic [XLEN-1:0]   rs2_fwd_val,
  output logic              sb_err
);

  localparam int unsigned NREG = 2**AW;

  typedef enum logic [1:0] {RR_0, RR_1, RR_2} rr_e;

  rr_e             rr_q, rr_d;
  logic [2:0]      grant;
  logic [1:0]      gidx;
  logic [AW-1:0]   g_rd;
  logic [XLEN-1:0] g_data;
  logic [CNTW-1:0] cnt [NREG];
  logic [NREG-1:0] inc_v, dec_v;
  logic            alloc_fire, commit_err;
  logic            rs1_base, rs2_base;

  always_comb begin
    grant = '0;
    if (!wb_stall && !rst) begin
      case (rr_q)
        RR_0:    if (req_valid[0]) grant = 3'b001; else if (req_valid[1]) grant = 3'b010;
                 else if (req_valid[2]) grant = 3'b100;
        RR_1:    if (req_valid[1]) grant = 3'b010; else if (req_valid[2]) grant = 3'b100;
                 else if (req_valid[0]) grant = 3'b001;
        default: if (req_valid[2]) grant = 3'b100; else if (req_valid[0]) grant = 3'b001;
                 else if (req_valid[1]) grant = 3'b010;
      endcase
    end
    rr_d = rr_q;
    gidx = 2'd0;
    if (grant[0]) rr_d = RR_1;
    if (grant[1]) begin rr_d = RR_2; gidx = 2'd1; end
    if (grant[2]) begin rr_d = RR_0; gidx = 2'd2; end
  end

  assign req_ready = grant;
  assign g_rd      = req_rd[32'(gidx)*AW +: AW];
  assign g_data    = req_data[32'(gidx)*XLEN +: XLEN];

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q    <= RR_0;
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
      sb_err  <= 1'b0;
    end else begin
      rr_q  <= rr_d;
      wb_we <= 1'b0;
      // A grant for x0 completes the handshake but never reaches the regfile.
      if (|grant) begin
        wb_we   <= (g_rd != '0);
        wb_rd   <= g_rd;
        wb_data <= g_data;
      end
      if (commit_err) sb_err <= 1'b1;
    end
  end

  assign alloc_ready = (alloc_rd == '0) || !(&cnt[alloc_rd]);
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign commit_err  = wb_we && (wb_rd != '0) && (cnt[wb_rd] == '0);

  always_comb begin
    for (int unsigned r = 0; r < NREG; r++) begin
      inc_v[r] = alloc_fire && (alloc_rd == AW'(r));
      dec_v[r] = wb_we && (wb_rd == AW'(r)) && (cnt[r] != '0);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned r = 0; r < NREG; r++) begin
      if (rst || r == 0)               cnt[r] <= '0;
      else if (inc_v[r] && !dec_v[r])  cnt[r] <= cnt[r] + CNTW'(1);
      else if (dec_v[r] && !inc_v[r])  cnt[r] <= cnt[r] - CNTW'(1);
    end
  end

  assign rs1_base = (rs1 != '0) && (cnt[rs1] != '0);
  assign rs2_base = (rs2 != '0) && (cnt[rs2] != '0);

`ifdef WB_FWD_EN
  logic rs1_hit, rs2_hit;
  // Last outstanding write is on the port right now: the reader can take it directly.
  assign rs1_hit     = wb_we && (wb_rd == rs1) && (rs1 != '0) && (cnt[rs1] == CNTW'(1));
  assign rs2_hit     = wb_we && (wb_rd == rs2) && (rs2 != '0) && (cnt[rs2] == CNTW'(1));
  assign rs1_busy    = rs1_base && !rs1_hit;
  assign rs2_busy    = rs2_base && !rs2_hit;
  assign rs1_fwd_val = rs1_hit ? wb_data : '0;
  assign rs2_fwd_val = rs2_hit ? wb_data : '0;
`else
  assign rs1_busy    = rs1_base;
  assign rs2_busy    = rs2_base;
  assign rs1_fwd_val = '0;
  assign rs2_fwd_val = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed stimulus plus a write-back scoreboard
// that records each granted result and matches it against the next-cycle regfile write.
module tb_wb_arbiter;

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 4;
  localparam int unsigned CNTW = 2;
`ifdef WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        req_valid;
  logic [3*AW-1:0]   req_rd;
  logic [3*XLEN-1:0] req_data;
  logic [2:0]        req_ready;
  logic              wb_stall;
  logic              wb_we;
  logic [AW-1:0]     wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              alloc_valid;
  logic [AW-1:0]     alloc_rd;
  logic              alloc_ready;
  logic [AW-1:0]     rs1, rs2;
  logic              rs1_busy, rs2_busy;
  logic [XLEN-1:0]   rs1_fwd_val, rs2_fwd_val;
  logic              sb_err;

  wb_arbiter #(.XLEN(XLEN), .AW(AW), .CNTW(CNTW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rd(req_rd), .req_data(req_data),
    .req_ready(req_ready), .wb_stall(wb_stall), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
    .alloc_ready(alloc_ready), .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy), .rs1_fwd_val(rs1_fwd_val), .rs2_fwd_val(rs2_fwd_val),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0]   rd;
    logic [XLEN-1:0] data;
  } wr_t;

  wr_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  mon_en = 1'b0;
  bit  exp_we = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] rd, input logic [XLEN-1:0] d);
    req_rd[i*AW +: AW]       = rd;
    req_data[i*XLEN +: XLEN] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Scoreboard: a handshake in cycle N must appear on the write port in N+1.
  always @(negedge clk) begin
    wr_t w;
    if (mon_en) begin
      check("wb_we", 64'(wb_we), 64'(exp_we));
      if (exp_we) begin
        check("sb_depth", 64'(sb_q.size()), 64'(1));
        if (sb_q.size() != 0) begin
          w = sb_q.pop_front();
          check("wb_rd", 64'(wb_rd), 64'(w.rd));
          check("wb_data", 64'(wb_data), 64'(w.data));
        end
      end
      check("ready_wo_valid", 64'(req_ready & ~req_valid), 64'(0));
      exp_we = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          w.rd   = req_rd[i*AW +: AW];
          w.data = req_data[i*XLEN +: XLEN];
          if (w.rd != '0) begin
            sb_q.push_back(w);
            exp_we = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] e;
    rst = 1'b1; req_valid = '0; req_rd = '0; req_data = '0; wb_stall = 1'b0;
    alloc_valid = 1'b0; alloc_rd = '0; rs1 = 4'd5; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    req_valid = 3'b111;
    #1;
    check("rst_gate", 64'(req_ready), 64'(0));
    check("rst_we", 64'(wb_we), 64'(0));
    check("rst_rd", 64'(wb_rd), 64'(0));
    check("rst_data", 64'(wb_data), 64'(0));
    check("rst_err", 64'(sb_err), 64'(0));
    check("rst_busy", 64'(rs1_busy), 64'(0));
    req_valid = '0;
    rst = 1'b0;
    mon_en = 1'b1;

    // Single transfer to x5 with a matching allocation.
    alloc_valid = 1'b1; alloc_rd = 4'd5;
    step();
    alloc_valid = 1'b0;
    set_req(0, 4'd5, 32'hDEADBEEF);
    req_valid = 3'b001;
    #1;
    check("single_grant", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    #1;
    check("single_we", 64'(wb_we), 64'(1));
    check("single_rd", 64'(wb_rd), 64'(5));
    check("single_data", 64'(wb_data), 64'(32'hDEADBEEF));
    check("single_busy_commit", 64'(rs1_busy), 64'(!FWD));
    step();
    check("single_we_off", 64'(wb_we), 64'(0));
    check("single_busy_done", 64'(rs1_busy), 64'(0));

    // Round robin with all three valid.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      alloc_valid = 1'b1;
      alloc_rd = AW'(k % 3 + 1);
      step();
    end
    alloc_valid = 1'b0;
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < 3; i++) set_req(i, AW'(i + 1), 32'hA000_0000 | XLEN'(c * 16 + i));
      req_valid = 3'b111;
      #1;
      e = 3'b001 << (c % 3);
      check("rr_grant", 64'(req_ready), 64'(e));
      step();
    end
    req_valid = '0;
    step();
    rs1 = 4'd1; rs2 = 4'd3;
    #1;
    check("rr_busy1", 64'(rs1_busy), 64'(0));
    check("rr_busy3", 64'(rs2_busy), 64'(0));
    check("rr_err", 64'(sb_err), 64'(0));

    // Stall, with x0 grants that must not write.
    for (int i = 0; i < 3; i++) set_req(i, '0, 32'h5555_0000 | XLEN'(i));
    req_valid = 3'b001;
    #1;
    check("x0_grant", 64'(req_ready), 64'(3'b001));
    step();
    check("x0_we", 64'(wb_we), 64'(0));
    wb_stall = 1'b1;
    req_valid = 3'b111;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_ready", 64'(req_ready), 64'(0));
      step();
    end
    wb_stall = 1'b0;
    #1;
    check("stall_release", 64'(req_ready), 64'(3'b010));
    step();
    req_valid = '0;

    // Saturate x7, then drain it with three commits.
    for (int k = 0; k < 3; k++) begin
      alloc_valid = 1'b1; alloc_rd = 4'd7;
      #1;
      check("alloc_ok", 64'(alloc_ready), 64'(1));
      step();
    end
    rs1 = 4'd7;
    #1;
    check("alloc_full", 64'(alloc_ready), 64'(0));
    check("busy7", 64'(rs1_busy), 64'(1));
    step();
    alloc_valid = 1'b0;
    req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      set_req(1, 4'd7, 32'hC0DE_0000 | XLEN'(k));
      #1;
      check("c7_grant", 64'(req_ready), 64'(3'b010));
      step();
      if (k < 2) begin
        check("c7_busy", 64'(rs1_busy), 64'(1));
        check("c7_fwd_none", 64'(rs1_fwd_val), 64'(0));
      end
    end
    req_valid = '0;
    #1;
    check("c7_last_busy", 64'(rs1_busy), 64'(!FWD));
    check("c7_last_fwd", 64'(rs1_fwd_val), FWD ? 64'(32'hC0DE_0002) : 64'(0));
    step();
    check("c7_done_busy", 64'(rs1_busy), 64'(0));
    check("c7_done_fwd", 64'(rs1_fwd_val), 64'(0));
    check("c7_err", 64'(sb_err), 64'(0));

    // Commit to x9 with nothing outstanding.
    set_req(2, 4'd9, 32'h0000_0099);
    req_valid = 3'b100;
    #1;
    check("err_grant", 64'(req_ready), 64'(3'b100));
    step();
    req_valid = '0;
    check("err_before", 64'(sb_err), 64'(0));
    step();
    rs2 = 4'd9;
    #1;
    check("err_set", 64'(sb_err), 64'(1));
    check("err_busy9", 64'(rs2_busy), 64'(0));
    step();
    step();
    check("err_held", 64'(sb_err), 64'(1));
    do_reset();
    #1;
    check("err_cleared", 64'(sb_err), 64'(0));

    // Allocation and commit to x3 in the same cycle.
    alloc_valid = 1'b1; alloc_rd = 4'd3;
    step();
    alloc_valid = 1'b0;
    set_req(0, 4'd3, 32'h0000_0033);
    req_valid = 3'b001;
    #1;
    check("same_grant", 64'(req_ready), 64'(3'b001));
    step();
    req_valid = '0;
    alloc_valid = 1'b1; alloc_rd = 4'd3;
    #1;
    check("same_alloc", 64'(alloc_ready), 64'(1));
    check("same_we", 64'(wb_we), 64'(1));
    step();
    alloc_valid = 1'b0;
    rs2 = 4'd3;
    #1;
    check("same_busy", 64'(rs2_busy), 64'(1));
    step();
    check("same_busy_hold", 64'(rs2_busy), 64'(1));

    step();
    check("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
